ddr_burst_arb: RTL and testbench



---
 rtl/ddr_burst_arb_pkg.sv | 14 +
 rtl/ddr_burst_arb_if.sv | 51 +++++
 rtl/ddr_burst_arb_rr_arbiter.sv | 30 +++
 rtl/ddr_burst_arb.sv | 143 ++++++++++++++
 tb/tb_ddr_burst_arb.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_burst_arb_pkg.sv
// Shared types and MIG command codes for the DDR burst arbiter.
package ddr_arb_pkg;

   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DONE
   } state_t;

endpackage

// File: rtl/ddr_burst_arb_if.sv
// Channel-side and MIG-side signal bundle of the burst arbiter.
interface ddr_burst_arb_if #(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128,
   parameter int LEN_W  = 16
) ();

   logic                     init_calib_complete;
   logic [NUM_CH-1:0]        ch_req;
   logic [NUM_CH-1:0]        ch_wr;
   logic [NUM_CH*ADDR_W-1:0] ch_addr;
   logic [NUM_CH*LEN_W-1:0]  ch_len;
   logic [NUM_CH*DATA_W-1:0] ch_wdata;
   logic [NUM_CH-1:0]        ch_ack;
   logic [NUM_CH-1:0]        ch_wdata_req;
   logic [DATA_W-1:0]        ch_rdata;
   logic [NUM_CH-1:0]        ch_rvalid;
   logic [NUM_CH-1:0]        ch_done;
   logic                     busy;
   logic [ADDR_W-1:0]        app_addr;
   logic [2:0]               app_cmd;
   logic                     app_en;
   logic [DATA_W-1:0]        app_wdf_data;
   logic                     app_wdf_wren;
   logic                     app_wdf_end;
   logic [DATA_W/8-1:0]      app_wdf_mask;
   logic                     app_rdy;
   logic                     app_wdf_rdy;
   logic [DATA_W-1:0]        app_rd_data;
   logic                     app_rd_data_valid;

   modport master (
      input  init_calib_complete, ch_req, ch_wr, ch_addr,
      input  ch_len, ch_wdata,
      input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
      output ch_ack, ch_wdata_req, ch_rdata, ch_rvalid, ch_done,
      output busy, app_addr, app_cmd, app_en,
      output app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask
   );

   modport slave (
      output init_calib_complete, ch_req, ch_wr, ch_addr,
      output ch_len, ch_wdata,
      output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
      input  ch_ack, ch_wdata_req, ch_rdata, ch_rvalid, ch_done,
      input  busy, app_addr, app_cmd, app_en,
      input  app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask
   );

endinterface

// File: rtl/ddr_burst_arb_rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr,
// searching upward with wrap.
module rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] i_req,
   input  logic [IDX_W-1:0]  i_ptr,
   output logic [NUM_CH-1:0] o_grant,
   output logic [IDX_W-1:0]  o_idx
);

   logic [IDX_W-1:0] w_j;

   // Scan from the farthest slot back so the nearest match wins last.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_j     = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         w_j = IDX_W'((int'(i_ptr) + k) % NUM_CH);
         if (i_req[w_j]) begin
            o_grant      = '0;
            o_grant[w_j] = 1'b1;
            o_idx        = w_j;
         end
      end
   end

endmodule

// File: rtl/ddr_burst_arb.sv
// Round-robin burst arbiter: grants one channel, streams its burst
// job to the MIG app interface and routes read data back.
module ddr_burst_arb
   import ddr_arb_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int ADDR_W   = 28,
   parameter int DATA_W   = 128,
   parameter int LEN_W    = 16,
   parameter int ADDR_INC = 8
) (
   input  logic            ui_clk,
   input  logic            sys_rst_n,
   ddr_burst_arb_if.master bus
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   state_t              r_state;
   state_t              w_state_nx;
   logic [IDX_W-1:0]    r_sel;
   logic [IDX_W-1:0]    r_ptr;
   logic [IDX_W-1:0]    w_gnt_idx;
   logic [NUM_CH-1:0]   w_gnt;
   logic [NUM_CH-1:0]   w_sel_oh;
   logic [NUM_CH-1:0]   r_ack;
   logic [NUM_CH-1:0]   r_done;
   logic [ADDR_W-1:0]   r_addr;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_issued;
   logic [LEN_W-1:0]    r_returned;
   logic [LEN_W-1:0]    w_iss_nx;
   logic [LEN_W-1:0]    w_ret_nx;
   logic [LEN_W-1:0]    w_gnt_len;
   logic                w_start;
   logic                w_more;
   logic                w_wr_acc;
   logic                w_rd_iss;
   logic                w_rd_ret;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_rr (
      .i_req   (bus.ch_req),
      .i_ptr   (r_ptr),
      .o_grant (w_gnt),
      .o_idx   (w_gnt_idx)
   );

   assign w_start = (r_state == S_IDLE)
                  & bus.init_calib_complete
                  & (|bus.ch_req);

   assign w_gnt_len = bus.ch_len[w_gnt_idx*LEN_W +: LEN_W];
   assign w_sel_oh  = NUM_CH'(1) << r_sel;
   assign w_more    = r_issued < r_len;

   assign w_wr_acc = (r_state == S_WRITE) & bus.app_rdy
                   & bus.app_wdf_rdy & w_more;
   assign w_rd_iss = (r_state == S_READ) & bus.app_rdy & w_more;
   assign w_rd_ret = (r_state == S_READ) & bus.app_rd_data_valid;

   assign w_iss_nx = r_issued + LEN_W'(w_wr_acc | w_rd_iss);
   assign w_ret_nx = r_returned + LEN_W'(w_rd_ret);

   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_start) begin
               if (w_gnt_len == '0)
                  w_state_nx = S_DONE;
               else if (bus.ch_wr[w_gnt_idx])
                  w_state_nx = S_WRITE;
               else
                  w_state_nx = S_READ;
            end
         end
         S_WRITE: begin
            if (w_wr_acc && (w_iss_nx == r_len))
               w_state_nx = S_DONE;
         end
         S_READ: begin
            // Bus is held until every issued read has come back.
            if ((w_iss_nx == r_len) && (w_ret_nx == r_len))
               w_state_nx = S_DONE;
         end
         S_DONE: w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge ui_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state    <= S_IDLE;
         r_sel      <= '0;
         r_ptr      <= '0;
         r_addr     <= '0;
         r_len      <= '0;
         r_issued   <= '0;
         r_returned <= '0;
         r_ack      <= '0;
         r_done     <= '0;
      end else begin
         r_state <= w_state_nx;
         r_ack   <= w_start ? w_gnt : '0;
         r_done  <= '0;
         if ((w_state_nx == S_DONE) && (r_state != S_DONE))
            r_done <= w_start ? w_gnt : w_sel_oh;
         if (w_start) begin
            r_sel      <= w_gnt_idx;
            r_addr     <= bus.ch_addr[w_gnt_idx*ADDR_W +: ADDR_W];
            r_len      <= w_gnt_len;
            r_issued   <= '0;
            r_returned <= '0;
            r_ptr      <= (w_gnt_idx == IDX_W'(NUM_CH - 1)) ?
                          '0 : w_gnt_idx + IDX_W'(1);
         end else begin
            r_issued   <= w_iss_nx;
            r_returned <= w_ret_nx;
            if (w_wr_acc | w_rd_iss)
               r_addr <= r_addr + ADDR_W'(ADDR_INC);
         end
      end
   end

   assign bus.ch_ack       = r_ack;
   assign bus.ch_done      = r_done;
   assign bus.busy         = (r_state != S_IDLE);
   assign bus.app_addr     = r_addr;
   assign bus.app_cmd      = (r_state == S_READ) ? CMD_RD : CMD_WR;
   assign bus.app_en       = w_wr_acc | w_rd_iss;
   assign bus.app_wdf_wren = w_wr_acc;
   assign bus.app_wdf_end  = w_wr_acc;
   assign bus.app_wdf_mask = '0;
   assign bus.app_wdf_data = (r_state == S_WRITE) ?
                             bus.ch_wdata[r_sel*DATA_W +: DATA_W] : '0;
   assign bus.ch_wdata_req = w_wr_acc ? w_sel_oh : '0;
   assign bus.ch_rvalid    = w_rd_ret ? w_sel_oh : '0;
   assign bus.ch_rdata     = (r_state == S_READ) ? bus.app_rd_data : '0;

endmodule

// File: tb/tb_ddr_burst_arb.sv
// Scoreboard bench for ddr_burst_arb: job-level model predicts
// grants, command streams, read returns and completions.
module tb_ddr_burst_arb;
   import ddr_arb_pkg::*;

   localparam int N   = 4;
   localparam int AW  = 28;
   localparam int DW  = 128;
   localparam int LW  = 16;
   localparam int INC = 8;

   typedef struct {
      int            ch;
      bit            wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } cmd_t;

   typedef struct {
      int            ch;
      logic [DW-1:0] d;
   } rv_t;

   typedef struct {
      int            due;
      logic [DW-1:0] d;
   } ret_t;

   logic ui_clk    = 1'b0;
   logic sys_rst_n = 1'b0;

   ddr_burst_arb_if #(
      .NUM_CH (N), .ADDR_W (AW), .DATA_W (DW), .LEN_W (LW)
   ) bus ();

   ddr_burst_arb #(
      .NUM_CH (N), .ADDR_W (AW), .DATA_W (DW),
      .LEN_W (LW), .ADDR_INC (INC)
   ) dut (
      .ui_clk    (ui_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   always #5 ui_clk = ~ui_clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int q_ack[$];
   int q_done[$];
   cmd_t q_cmd[$];
   rv_t q_rv[$];
   ret_t ret_q[$];
   int ptr_m = 0;
   int wexp[N];
   int wbeat[N];
   int rdy_mode = 0;
   int lat_lo = 10;
   int lat_hi = 10;
   int last_due = 0;
   int last_ack_cyc = 0;
   int last_done_cyc = 0;
   int n_rv = 0;
   int jl[N];
   bit jw[N];
   logic [AW-1:0] ja[N];

   function automatic logic [DW-1:0] wdf(int c, int n);
      return {32'(c), 32'(n), 32'hC0DE_0000 + 32'(n), 32'(c * 1000 + n)};
   endfunction

   function automatic logic [DW-1:0] rdf(logic [AW-1:0] a);
      return {32'(a) ^ 32'h5A5A_5A5A, 32'(a),
              64'hFEED_0000_0000_0000 | 64'(a)};
   endfunction

   task automatic check(bit ok, string nm,
                        logic [DW-1:0] act, logic [DW-1:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Channel sources and MIG responder
   initial begin : drv
      logic [N-1:0]  s_ack;
      logic [N-1:0]  s_wreq;
      bit            s_rd;
      logic [AW-1:0] s_a;
      int            due;
      forever begin
         @(negedge ui_clk);
         s_ack  = bus.ch_ack;
         s_wreq = bus.ch_wdata_req;
         s_rd   = bus.app_en && bus.app_rdy && (bus.app_cmd == CMD_RD);
         s_a    = bus.app_addr;
         @(posedge ui_clk);
         cyc++;
         #1;
         for (int c = 0; c < N; c++) begin
            if (s_ack[c]) bus.ch_req[c] = 1'b0;
            if (s_wreq[c]) begin
               wbeat[c]++;
               bus.ch_wdata[c*DW +: DW] = wdf(c, wbeat[c]);
            end
         end
         if (s_rd) begin
            due = cyc + int'($urandom_range(lat_hi, lat_lo)) - 1;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            ret_q.push_back('{due, rdf(s_a)});
         end
         bus.app_rd_data_valid = 1'b0;
         if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            bus.app_rd_data       = ret_q[0].d;
            bus.app_rd_data_valid = 1'b1;
            void'(ret_q.pop_front());
         end
         case (rdy_mode)
            0: begin
               bus.app_rdy     = 1'b1;
               bus.app_wdf_rdy = 1'b1;
            end
            1: begin
               bus.app_rdy     = 1'b1;
               bus.app_wdf_rdy = cyc[0];
            end
            default: begin
               bus.app_rdy     = ($urandom_range(3, 0) != 0);
               bus.app_wdf_rdy = ($urandom_range(3, 0) != 0);
            end
         endcase
      end
   end

   // Monitor: pop expectations whenever the DUT presents an event
   always @(negedge ui_clk) begin : mon
      int   e;
      int   pend;
      cmd_t ec;
      rv_t  er;
      check((bus.app_wdf_wren == (bus.app_en && bus.app_cmd == CMD_WR))
            && (bus.app_wdf_end == bus.app_wdf_wren)
            && ($countones(bus.ch_wdata_req) == int'(bus.app_wdf_wren))
            && (bus.app_wdf_mask == '0),
            "wdf_strobes", DW'(bus.ch_wdata_req), DW'(bus.app_wdf_wren));
      if (bus.ch_ack != '0) begin
         if (q_ack.size() == 0) begin
            check(1'b0, "ack_unexpected", DW'(bus.ch_ack), '0);
         end else begin
            e = q_ack.pop_front();
            last_ack_cyc = cyc;
            check(bus.ch_ack == (4'(1) << e), "ack_chan",
                  DW'(bus.ch_ack), DW'(4'(1) << e));
         end
      end
      if (bus.app_en) begin
         if (!(bus.app_rdy &&
               (bus.app_cmd == CMD_RD || bus.app_wdf_rdy))) begin
            check(1'b0, "en_without_rdy", DW'(bus.app_rdy), 1);
         end else if (q_cmd.size() == 0) begin
            check(1'b0, "cmd_unexpected", DW'(bus.app_addr), '0);
         end else begin
            ec = q_cmd.pop_front();
            check(bus.app_addr == ec.a, "cmd_addr",
                  DW'(bus.app_addr), DW'(ec.a));
            check(bus.app_cmd == (ec.wr ? CMD_WR : CMD_RD), "cmd_type",
                  DW'(bus.app_cmd), DW'(ec.wr ? CMD_WR : CMD_RD));
            if (ec.wr) begin
               check(bus.app_wdf_data == ec.d, "wdata",
                     bus.app_wdf_data, ec.d);
               check(bus.ch_wdata_req == (4'(1) << ec.ch), "wdata_req",
                     DW'(bus.ch_wdata_req), DW'(4'(1) << ec.ch));
            end
         end
      end
      if (bus.ch_rvalid != '0) begin
         if (q_rv.size() == 0) begin
            check(1'b0, "rvalid_unexpected", DW'(bus.ch_rvalid), '0);
         end else begin
            er = q_rv.pop_front();
            n_rv++;
            check(bus.ch_rvalid == (4'(1) << er.ch), "rvalid_chan",
                  DW'(bus.ch_rvalid), DW'(4'(1) << er.ch));
            check(bus.ch_rdata == er.d, "rdata", bus.ch_rdata, er.d);
         end
      end
      if (bus.ch_done != '0) begin
         if (q_done.size() == 0) begin
            check(1'b0, "done_unexpected", DW'(bus.ch_done), '0);
         end else begin
            e = q_done.pop_front();
            last_done_cyc = cyc;
            check(bus.ch_done == (4'(1) << e), "done_chan",
                  DW'(bus.ch_done), DW'(4'(1) << e));
            pend = 0;
            foreach (q_cmd[i]) if (q_cmd[i].ch == e) pend++;
            foreach (q_rv[i]) if (q_rv[i].ch == e) pend++;
            check(pend == 0, "done_early", DW'(pend), '0);
         end
      end
   end

   task automatic clear_jobs();
      for (int c = 0; c < N; c++) begin
         jl[c] = 0;
         jw[c] = 1'b0;
         ja[c] = '0;
      end
   endtask

   task automatic job(int c, bit wr, logic [AW-1:0] a, int len);
      jw[c] = wr;
      ja[c] = a;
      jl[c] = len;
   endtask

   // Grant order follows the round-robin rule over the held requests.
   task automatic launch(logic [N-1:0] mask);
      int c;
      int last;
      logic [AW-1:0] a;
      last = -1;
      for (int k = 0; k < N; k++) begin
         c = (ptr_m + k) % N;
         if (mask[c]) begin
            q_ack.push_back(c);
            q_done.push_back(c);
            last = c;
            for (int b = 0; b < jl[c]; b++) begin
               a = AW'(ja[c] + b * INC);
               if (jw[c]) begin
                  q_cmd.push_back('{c, 1'b1, a, wdf(c, wexp[c] + b)});
               end else begin
                  q_cmd.push_back('{c, 1'b0, a, '0});
                  q_rv.push_back('{c, rdf(a)});
               end
            end
            if (jw[c]) wexp[c] += jl[c];
            bus.ch_wr[c]             = jw[c];
            bus.ch_addr[c*AW +: AW]  = ja[c];
            bus.ch_len[c*LW +: LW]   = LW'(jl[c]);
            bus.ch_req[c]            = 1'b1;
         end
      end
      if (last >= 0) ptr_m = (last + 1) % N;
   endtask

   task automatic flush();
      q_ack.delete();
      q_done.delete();
      q_cmd.delete();
      q_rv.delete();
   endtask

   task automatic wait_done(int budget);
      int t;
      t = 0;
      while ((q_ack.size() > 0 || q_done.size() > 0) && t < budget) begin
         @(posedge ui_clk);
         t++;
      end
      if (q_ack.size() > 0 || q_done.size() > 0) begin
         check(1'b0, "timeout", DW'(q_done.size()), '0);
         flush();
      end
      @(posedge ui_clk);
      #1;
      check(bus.busy == 1'b0, "idle_after_job", DW'(bus.busy), '0);
   endtask

   task automatic check_zero(string nm);
      check(bus.busy == 0 && bus.ch_ack == 0 && bus.ch_done == 0,
            {nm, "_ctl"}, DW'({bus.busy, bus.ch_ack, bus.ch_done}), '0);
      check(bus.app_en == 0 && bus.app_wdf_wren == 0 &&
            bus.app_wdf_end == 0 && bus.ch_wdata_req == 0 &&
            bus.ch_rvalid == 0, {nm, "_en"},
            DW'({bus.app_en, bus.app_wdf_wren, bus.ch_rvalid}), '0);
      check(bus.app_addr == 0 && bus.app_cmd == 0, {nm, "_addr"},
            DW'(bus.app_addr), '0);
      check(bus.app_wdf_data == 0 && bus.ch_rdata == 0, {nm, "_data"},
            bus.app_wdf_data | bus.ch_rdata, '0);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      logic [N-1:0] mask;
      bus.init_calib_complete = 1'b0;
      bus.ch_req              = '0;
      bus.ch_wr               = '0;
      bus.ch_addr             = '0;
      bus.ch_len              = '0;
      bus.app_rdy             = 1'b0;
      bus.app_wdf_rdy         = 1'b0;
      bus.app_rd_data         = '0;
      bus.app_rd_data_valid   = 1'b0;
      for (int c = 0; c < N; c++) begin
         wbeat[c] = 0;
         wexp[c]  = 0;
         bus.ch_wdata[c*DW +: DW] = wdf(c, 0);
      end
      repeat (3) @(posedge ui_clk);
      #1;
      check_zero("reset");
      @(negedge ui_clk);
      sys_rst_n = 1'b1;
      bus.init_calib_complete = 1'b1;
      @(posedge ui_clk);
      #1;

      // All channels requesting at once, then channel 0 alone
      clear_jobs();
      for (int c = 0; c < N; c++) job(c, 1'b1, AW'(c * 64), 1);
      launch(4'b1111);
      wait_done(200);
      clear_jobs();
      job(0, 1'b0, 28'h2000, 1);
      launch(4'b0001);
      wait_done(200);

      // Channel 1 write, always-ready MIG
      clear_jobs();
      job(1, 1'b1, 28'h100, 4);
      launch(4'b0010);
      wait_done(200);
      check(last_done_cyc - last_ack_cyc == 4, "wr_done_latency",
            DW'(last_done_cyc - last_ack_cyc), 4);

      // Channel 2 read with 10-cycle return latency
      clear_jobs();
      n_rv = 0;
      job(2, 1'b0, 28'h300, 3);
      launch(4'b0100);
      wait_done(200);
      check(n_rv == 3, "rv_count", DW'(n_rv), 3);

      // Write data ready on alternate cycles
      rdy_mode = 1;
      clear_jobs();
      job(3, 1'b1, 28'h400, 4);
      launch(4'b1000);
      wait_done(200);
      rdy_mode = 0;

      // Address wrap at the top of the space
      clear_jobs();
      job(0, 1'b1, 28'hFFFFFF8, 2);
      launch(4'b0001);
      wait_done(200);

      // Zero-length job
      clear_jobs();
      job(1, 1'b0, 28'h500, 0);
      launch(4'b0010);
      wait_done(200);

      // Calibration low blocks grants
      bus.init_calib_complete = 1'b0;
      clear_jobs();
      job(2, 1'b1, 28'h600, 2);
      launch(4'b0100);
      repeat (10) @(posedge ui_clk);
      #1;
      check(q_ack.size() == 1 && bus.busy == 0, "no_grant_uncal",
            DW'(bus.busy), '0);
      bus.init_calib_complete = 1'b1;
      wait_done(200);

      // Reset in the middle of a read job
      clear_jobs();
      job(2, 1'b0, 28'h700, 4);
      launch(4'b0100);
      for (int t = 0; t < 20 && q_ack.size() > 0; t++)
         @(posedge ui_clk);
      repeat (2) @(posedge ui_clk);
      #1;
      sys_rst_n = 1'b0;
      flush();
      ptr_m = 0;
      #1;
      check_zero("midreset");
      repeat (2) @(posedge ui_clk);
      @(negedge ui_clk);
      sys_rst_n = 1'b1;
      repeat (20) @(posedge ui_clk);
      #1;
      check(bus.busy == 0, "idle_after_reset", DW'(bus.busy), '0);

      // Randomized job sets
      rdy_mode = 2;
      lat_lo   = 1;
      lat_hi   = 12;
      repeat (30) begin
         clear_jobs();
         mask = N'($urandom_range(15, 1));
         for (int c = 0; c < N; c++)
            job(c, 1'($urandom), AW'($urandom) & ~AW'(7),
                int'($urandom_range(6, 0)));
         launch(mask);
         wait_done(2000);
      end

      check(q_cmd.size() == 0 && q_rv.size() == 0, "leftover",
            DW'(q_cmd.size() + q_rv.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
